// File: rtl/px_scan_pkg.sv
// Shared types and constants for the pixel oscillator scan sequencer.
// No logic of its own; the helper functions are pure combinational.
// PXSCAN_CONT_EN (optional continuous scanning) does not affect this file.
package px_scan_pkg;

    localparam int NPX        = 16;
    localparam int PX_W       = 4;
    localparam int CNT_W_DFLT = 16;
    localparam int GATE_W     = 16;
    localparam int SETTLE_CYC = 8;

    // Every oscillator halted, index field don't-care
    localparam logic [4:0] STOP_ALL = 5'b10000;

    typedef enum logic [2:0] {IDLE, SETTLE, GATE, STORE, DONE} state_t;

    typedef struct packed {
        logic            vld;
        logic [PX_W-1:0] idx;
    } px_sel_t;

    // Lowest set bit of the mask
    function automatic px_sel_t lowest_set(input logic [NPX-1:0] mask);
        px_sel_t r;
        r = '0;
        for (int i = NPX - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.vld = 1'b1;
                r.idx = PX_W'(i);
            end
        end
        return r;
    endfunction

    // Lowest set bit strictly above 'from'
    function automatic px_sel_t next_set(input logic [NPX-1:0] mask, input logic [PX_W-1:0] from);
        px_sel_t r;
        r = '0;
        for (int i = NPX - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(from))) begin
                r.vld = 1'b1;
                r.idx = PX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/px_scan_ctrl_if.sv
// Register-block side of the scan sequencer: command inputs and result write port.
// Pure wiring, no latency; no backpressure, results are fire-and-forget strobes.
// PXSCAN_CONT_EN adds the 'cont' request line from the register block.
interface px_scan_ctrl_if #(parameter int CNT_W = px_scan_pkg::CNT_W_DFLT);
    import px_scan_pkg::*;

    logic              start;
    logic              abort;
    logic [NPX-1:0]    px_mask;
    logic [GATE_W-1:0] gate_len;
`ifdef PXSCAN_CONT_EN
    logic              cont;
`endif
    logic              busy;
    logic              res_we;
    logic [PX_W-1:0]   res_addr;
    logic [CNT_W-1:0]  res_data;
    logic              res_ovf;
    logic              drdy;

    modport master (
        output start, abort, px_mask, gate_len,
`ifdef PXSCAN_CONT_EN
        output cont,
`endif
        input  busy, res_we, res_addr, res_data, res_ovf, drdy
    );

    modport slave (
        input  start, abort, px_mask, gate_len,
`ifdef PXSCAN_CONT_EN
        input  cont,
`endif
        output busy, res_we, res_addr, res_data, res_ovf, drdy
    );

endinterface

// File: rtl/px_edge_cnt.sv
// Synchronises one raw oscillator output and counts its rising edges while enabled.
// Edge reaches the counter 3 clk after it occurs (2-FF sync + edge detect).
// No backpressure; counter saturates at all-ones and latches ovf until cleared.
module px_edge_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic sync1, sync2, sync3;
    logic rise;

    assign rise = sync2 & ~sync3;

    // Synchroniser, edge history and saturating edge counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            sync3 <= sync2;
            if (clr) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if (en && rise) begin
                if (cnt == '1) ovf <= 1'b1;
                else           cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/px_scan_ctrl.sv
// Scans enabled pixel oscillators in ascending order, writing one edge count per pixel.
// Per pixel SETTLE_CYC + gate_len + 1 clk to res_we; drdy one clk after the last write.
// No backpressure: start while busy is dropped, abort wins over everything. PXSCAN_CONT_EN: looping scans.
module px_scan_ctrl
    import px_scan_pkg::*;
#(
    parameter int CNT_W = CNT_W_DFLT
) (
    input  logic            clk,
    input  logic            rst,
    px_scan_ctrl_if.slave   rb,
    input  logic [NPX-1:0]  clk_px,
    output logic [4:0]      stop_osc,
    output logic [PX_W-1:0] px_addr
);

    state_t            state, nxt_state;
    logic [NPX-1:0]    mask_q;
    logic [GATE_W-1:0] gl_q;
    logic [GATE_W-1:0] tmr;
    logic [PX_W-1:0]   idx;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              settle_end, gate_end, restart;
    px_sel_t           first_in, first_q, nxt_sel;

    assign first_in   = lowest_set(rb.px_mask);
    assign first_q    = lowest_set(mask_q);
    assign nxt_sel    = next_set(mask_q, idx);
    assign settle_end = (tmr == GATE_W'(SETTLE_CYC - 1));
    assign gate_end   = (tmr == gl_q - GATE_W'(1));

`ifdef PXSCAN_CONT_EN
    assign restart = rb.cont && first_q.vld;
`else
    assign restart = 1'b0;
`endif

    // Only the pixel under measurement feeds the counter
    px_edge_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .din (clk_px[idx]),
        .en  (state == GATE),
        .clr (state == SETTLE),
        .cnt (cnt),
        .ovf (ovf)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt_state;
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        nxt_state = state;
        if (rb.abort) begin
            nxt_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (rb.start) nxt_state = first_in.vld ? SETTLE : DONE;
                SETTLE:  if (settle_end) nxt_state = GATE;
                GATE:    if (gate_end) nxt_state = STORE;
                STORE:   nxt_state = nxt_sel.vld ? SETTLE : DONE;
                DONE:    nxt_state = restart ? SETTLE : IDLE;
                default: nxt_state = IDLE;
            endcase
        end
    end

    // Scan context, timer and registered outputs; stop_osc moves in step with the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q      <= '0;
            gl_q        <= GATE_W'(1);
            tmr         <= '0;
            idx         <= '0;
            stop_osc    <= STOP_ALL;
            px_addr     <= '0;
            rb.busy     <= 1'b0;
            rb.res_we   <= 1'b0;
            rb.res_addr <= '0;
            rb.res_data <= '0;
            rb.res_ovf  <= 1'b0;
            rb.drdy     <= 1'b0;
        end else if (rb.abort) begin
            tmr       <= '0;
            stop_osc  <= STOP_ALL;
            rb.busy   <= 1'b0;
            rb.res_we <= 1'b0;
            rb.drdy   <= 1'b0;
        end else begin
            rb.res_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (rb.start) begin
                        mask_q  <= rb.px_mask;
                        gl_q    <= (rb.gate_len == '0) ? GATE_W'(1) : rb.gate_len;
                        tmr     <= '0;
                        rb.drdy <= 1'b0;
                        rb.busy <= 1'b1;
                        if (first_in.vld) begin
                            idx      <= first_in.idx;
                            stop_osc <= {1'b0, first_in.idx};
                            px_addr  <= first_in.idx;
                        end
                    end
                end
                SETTLE: begin
                    rb.drdy <= 1'b0;
                    tmr     <= settle_end ? '0 : tmr + GATE_W'(1);
                end
                GATE: begin
                    tmr <= gate_end ? '0 : tmr + GATE_W'(1);
                end
                STORE: begin
                    rb.res_we   <= 1'b1;
                    rb.res_addr <= idx;
                    rb.res_data <= cnt;
                    rb.res_ovf  <= ovf;
                    if (nxt_sel.vld) begin
                        idx      <= nxt_sel.idx;
                        stop_osc <= {1'b0, nxt_sel.idx};
                        px_addr  <= nxt_sel.idx;
                    end
                end
                DONE: begin
                    rb.drdy <= 1'b1;
                    if (restart) begin
                        idx      <= first_q.idx;
                        stop_osc <= {1'b0, first_q.idx};
                        px_addr  <= first_q.idx;
                    end else begin
                        stop_osc <= STOP_ALL;
                        rb.busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_px_scan_ctrl.sv
// Self-checking bench for px_scan_ctrl: directed scenarios plus randomised scans.
// Expected write order, timing and counts come from the mask bits and oscillator periods.
// A second instance with a 4-bit counter exercises saturation.
module tb_px_scan_ctrl;
    import px_scan_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    px_scan_ctrl_if #(.CNT_W(CNT_W_DFLT)) rb ();
    px_scan_ctrl_if #(.CNT_W(4))          rb4 ();

    logic [NPX-1:0]  clk_px;
    logic [4:0]      stop_osc, stop_osc4;
    logic [PX_W-1:0] px_addr, px_addr4;

    px_scan_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .rb       (rb),
        .clk_px   (clk_px),
        .stop_osc (stop_osc),
        .px_addr  (px_addr)
    );

    px_scan_ctrl #(.CNT_W(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .rb       (rb4),
        .clk_px   (clk_px),
        .stop_osc (stop_osc4),
        .px_addr  (px_addr4)
    );

    // Pixel oscillators: period per[i] clk cycles, high for the first half
    int per [NPX] = '{default: 4};
    int ph  [NPX] = '{default: 0};
    always @(negedge clk) begin
        for (int i = 0; i < NPX; i++) begin
            ph[i] = (ph[i] + 1 >= per[i]) ? 0 : ph[i] + 1;
            clk_px[i] = (ph[i] < per[i] / 2);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
        n_cmp++;
        assert (!$isunknown(obs) && int'(obs) >= lo && int'(obs) <= hi) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // One full scan. Cycle c = number of clk edges after the edge that sampled start.
    // Pixel j is written at c=(j+1)*(gate+9); drdy rises one cycle after the last write.
    // If poke>=0 a conflicting start is pulsed mid-scan and must be ignored.
    task automatic run_scan(input logic [15:0] mask, input int gl, input int poke);
        int gle, n, wr, drdy_at, last, p, lo, hi;
        logic [3:0] exp_idx[$];
        logic [4:0] prev_stop;
        gle = (gl == 0) ? 1 : gl;
        for (int i = 0; i < NPX; i++) if (mask[i]) exp_idx.push_back(4'(i));
        n = exp_idx.size();
        last = n * (gle + 9) + 1;
        rb.px_mask  = mask;
        rb.gate_len = 16'(gl);
        rb.start    = 1'b1;
        @(negedge clk);
        rb.start    = 1'b0;
        rb.px_mask  = 16'($urandom);
        rb.gate_len = 16'($urandom);
        wr = 0;
        drdy_at = -1;
        prev_stop = stop_osc;
        for (int c = 0; c <= last + 2; c++) begin
            if (c == 1) chk("drdy_at_c1", 32'(rb.drdy), 32'(n == 0));
            if (rb.res_we === 1'b1) begin
                if (wr < n) begin
                    p  = per[exp_idx[wr]];
                    lo = gle / p;
                    hi = (gle + p - 1) / p;
                    chk("wr_cycle", c, (wr + 1) * (gle + 9));
                    chk("wr_addr", 32'(rb.res_addr), 32'(exp_idx[wr]));
                    chk("stop_osc_meas", 32'(prev_stop), {27'd0, 1'b0, exp_idx[wr]});
                    chk_rng("wr_data", 32'(rb.res_data), lo, hi);
                    chk("wr_ovf", 32'(rb.res_ovf), 0);
                end
                wr++;
            end
            if (rb.drdy === 1'b1 && drdy_at < 0) drdy_at = c;
            prev_stop = stop_osc;
            if (c == poke) begin
                rb.start = 1'b1;
                rb.px_mask = '1;
                rb.gate_len = 16'd3;
            end else begin
                rb.start = 1'b0;
            end
            @(negedge clk);
        end
        chk("n_writes", wr, n);
        chk("drdy_cycle", drdy_at, last);
        chk("end_busy", 32'(rb.busy), 0);
        chk("end_stop", 32'(stop_osc), 32'(STOP_ALL));
        chk("end_drdy", 32'(rb.drdy), 1);
    endtask

    // Scan that is aborted after cycle abort_c; exp_wr writes must precede it
    task automatic abort_scan(input logic [15:0] mask, input int gl, input int abort_c, input int exp_wr);
        int wr;
        logic seen_drdy;
        rb.px_mask  = mask;
        rb.gate_len = 16'(gl);
        rb.start    = 1'b1;
        @(negedge clk);
        rb.start = 1'b0;
        wr = 0;
        seen_drdy = 1'b0;
        for (int c = 0; c <= abort_c + 80; c++) begin
            if (rb.res_we === 1'b1) wr++;
            if (rb.drdy !== 1'b0) seen_drdy = 1'b1;
            if (c == abort_c + 1) begin
                chk("abort_stop", 32'(stop_osc), 32'(STOP_ALL));
                chk("abort_busy", 32'(rb.busy), 0);
                chk("abort_we", 32'(rb.res_we), 0);
            end
            rb.abort = (c == abort_c);
            @(negedge clk);
        end
        chk("abort_writes", wr, exp_wr);
        chk("abort_drdy", 32'(seen_drdy), 0);
    endtask

    initial begin
        logic [15:0] m;
        int gl, wr, found, fc;
        rst = 1'b0;
        rb.start = 1'b0;  rb.abort = 1'b0;  rb.px_mask = '0;  rb.gate_len = '0;
        rb4.start = 1'b0; rb4.abort = 1'b0; rb4.px_mask = '0; rb4.gate_len = '0;
`ifdef PXSCAN_CONT_EN
        rb.cont = 1'b0;
        rb4.cont = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_stop", 32'(stop_osc), 32'(STOP_ALL));
        chk("rst_addr", 32'(px_addr), 0);
        chk("rst_busy", 32'(rb.busy), 0);
        chk("rst_we", 32'(rb.res_we), 0);
        chk("rst_res_addr", 32'(rb.res_addr), 0);
        chk("rst_data", 32'(rb.res_data), 0);
        chk("rst_ovf", 32'(rb.res_ovf), 0);
        chk("rst_drdy", 32'(rb.drdy), 0);
        rst = 1'b1;
        @(negedge clk);

        // Directed scans: single pixel, spread mask with ignored restart, empty mask, gate 0
        per[0] = 4;
        run_scan(16'h0001, 100, -1);
        run_scan(16'h8421, 20, 7);
        run_scan(16'h0000, 9, -1);
        run_scan(16'h0240, 0, -1);

        // Randomised scans
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NPX; i++) per[i] = $urandom_range(3, 12);
            m = 16'($urandom & $urandom);
            if (m == 16'h0000) m = 16'h0001;
            gl = $urandom_range(1, 30);
            run_scan(m, gl, $urandom_range(1, gl + 8));
        end

        // Saturation on the 4-bit counter instance
        per[3] = 4;
        rb4.px_mask = 16'h0008;
        rb4.gate_len = 16'd200;
        rb4.start = 1'b1;
        @(negedge clk);
        rb4.start = 1'b0;
        found = 0;
        fc = -1;
        for (int c = 0; c < 300 && found == 0; c++) begin
            if (rb4.res_we === 1'b1) begin
                found = 1;
                fc = c;
                chk("sat_addr", 32'(rb4.res_addr), 3);
                chk("sat_data", 32'(rb4.res_data), 15);
                chk("sat_ovf", 32'(rb4.res_ovf), 1);
            end
            @(negedge clk);
        end
        chk("sat_cycle", fc, 209);
        repeat (4) @(negedge clk);

        // Abort in GATE of pixel 2, then a full rescan; abort landing on STORE
        abort_scan(16'h000F, 20, 73, 2);
        run_scan(16'h000F, 20, -1);
        abort_scan(16'h0001, 5, 13, 0);
        run_scan(16'h0003, 6, -1);

        // start and abort together from IDLE: start dropped, sticky drdy cleared
        rb.px_mask = 16'h000F;
        rb.gate_len = 16'd5;
        rb.start = 1'b1;
        rb.abort = 1'b1;
        @(negedge clk);
        rb.start = 1'b0;
        rb.abort = 1'b0;
        chk("sa_busy", 32'(rb.busy), 0);
        chk("sa_drdy", 32'(rb.drdy), 0);
        chk("sa_stop", 32'(stop_osc), 32'(STOP_ALL));
        wr = 0;
        for (int c = 0; c < 40; c++) begin
            if (rb.res_we === 1'b1 || rb.busy === 1'b1) wr++;
            @(negedge clk);
        end
        chk("sa_activity", wr, 0);

        // Reset asserted mid-GATE takes effect without a clock edge
        rb.px_mask = 16'h0001;
        rb.gate_len = 16'd50;
        rb.start = 1'b1;
        @(negedge clk);
        rb.start = 1'b0;
        repeat (30) @(negedge clk);
        chk("pre_rst_stop", 32'(stop_osc), 0);
        rst = 1'b0;
        #1;
        chk("mrst_stop", 32'(stop_osc), 32'(STOP_ALL));
        chk("mrst_busy", 32'(rb.busy), 0);
        chk("mrst_data", 32'(rb.res_data), 0);
        chk("mrst_res_addr", 32'(rb.res_addr), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_scan(16'h0001, 10, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
